// File: rtl/ling_pkg.sv
// Shared definitions for the Ling Han-Carlson subtractor: operand width,
// the (H, I) span pair carried across the pipeline register, and the prefix merge.
package ling_pkg;

    localparam int LING_W = 12;

    typedef struct packed {
        logic h;
        logic i;
    } ling_span_t;

    // Ling group merge: upper span absorbs lower span.
    function automatic ling_span_t ling_merge(ling_span_t hi, ling_span_t lo);
        ling_span_t r;
        r.h = hi.h | (hi.i & lo.h);
        r.i = hi.i & lo.i;
        return r;
    endfunction

endpackage

// File: rtl/ling_hc_subtractor_pipe_tree.sv
// Combinational Ling Han-Carlson prefix tree, split into a front half (p/g -> spans)
// and a back half (registered spans -> pseudo-carries h and real carries c).
module ling_hc_sub_tree
    import ling_pkg::*;
(
    input  logic [10:0]       i_f_p,
    input  logic [11:0]       i_f_g,
    output logic              o_f_h_1_0,
    output logic              o_f_h_3_0,
    output ling_span_t [3:0]  o_f_span,
    input  logic [11:0]       i_b_p,
    input  logic [6:0]        i_b_g_even,
    input  logic              i_b_h_1_0,
    input  logic              i_b_h_3_0,
    input  ling_span_t [3:0]  i_b_span,
    output logic [LING_W:1]   o_b_h,
    output logic [LING_W:1]   o_b_c
);

    ling_span_t [5:1] w_l1;
    ling_span_t       w_s9_2;
    ling_span_t       w_s11_4;
    logic [LING_W:0]  w_h;

    genvar gi;
    generate
        // First level pairs odd position 2k+1 with even position 2k.
        for (gi = 1; gi < 6; gi++) begin : g_l1
            assign w_l1[gi].h = i_f_g[2*gi+1] | (i_f_p[2*gi] & i_f_g[2*gi]);
            assign w_l1[gi].i = i_f_p[2*gi] & i_f_p[2*gi-1];
        end
        for (gi = 0; gi < 4; gi++) begin : g_l2
            assign o_f_span[gi] = ling_merge(w_l1[gi+2], w_l1[gi+1]);
        end
    endgenerate

    assign o_f_h_1_0 = i_f_g[1] | (i_f_p[0] & i_f_g[0]);
    assign o_f_h_3_0 = w_l1[1].h | (w_l1[1].i & o_f_h_1_0);

    // Back half: spans 5_2, 7_4, 9_6, 11_8 in i_b_span[0..3].
    assign w_s9_2  = ling_merge(i_b_span[2], i_b_span[0]);
    assign w_s11_4 = ling_merge(i_b_span[3], i_b_span[1]);

    assign w_h[0]  = i_b_g_even[0];
    assign w_h[1]  = i_b_h_1_0;
    assign w_h[3]  = i_b_h_3_0;
    assign w_h[5]  = i_b_span[0].h | (i_b_span[0].i & i_b_h_1_0);
    assign w_h[7]  = i_b_span[1].h | (i_b_span[1].i & i_b_h_3_0);
    assign w_h[9]  = w_s9_2.h | (w_s9_2.i & i_b_h_1_0);
    assign w_h[11] = w_s11_4.h | (w_s11_4.i & i_b_h_3_0);

    generate
        // Han-Carlson fix-up: even positions take one grey step from their odd neighbour.
        for (gi = 1; gi < 7; gi++) begin : g_even
            assign w_h[2*gi] = i_b_g_even[gi] | (i_b_p[2*gi-1] & w_h[2*gi-1]);
        end
        for (gi = 1; gi <= LING_W; gi++) begin : g_carry
            assign o_b_c[gi] = i_b_p[gi-1] & w_h[gi-1];
        end
    endgenerate

    assign o_b_h = w_h[LING_W:1];

endmodule

// File: rtl/ling_hc_subtractor_pipe.sv
// Two-stage valid/ready pipelined subtractor (a - b - bin) built on the Ling
// Han-Carlson tree; the prefix tree is cut by the S1 register.
module ling_hc_subtractor_pipe
    import ling_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_bout,
    output logic             out_zero,
    output logic             out_ovf
);

    if (WIDTH != LING_W) begin : g_width_check
        $error("ling_hc_subtractor_pipe: WIDTH must be 12");
    end

    logic [LING_W:0]   w_p;
    logic [LING_W:0]   w_g;
    logic              w_h_1_0;
    logic              w_h_3_0;
    ling_span_t [3:0]  w_span;
    logic [LING_W:1]   w_h;
    logic [LING_W:1]   w_c;
    logic [6:0]        w_g_even;
    logic [LING_W-1:0] w_diff;
    logic              w_cout;
    logic              w_ovf;
    logic              w_s1_adv;
    logic              w_s2_adv;

    logic              r_s1_valid;
    logic [LING_W:0]   r_p;
    logic [LING_W:0]   r_g;
    logic              r_h_1_0;
    logic              r_h_3_0;
    ling_span_t [3:0]  r_span;
    logic              r_a_msb;
    logic              r_b_msb;

    logic              r_s2_valid;
    logic [LING_W-1:0] r_diff;
    logic              r_bout;
    logic              r_zero;
    logic              r_ovf;

    // Subtraction as a + ~b + ~bin; the borrow-in becomes the position-0 generate.
    assign w_p = {in_a | ~in_b, 1'b1};
    assign w_g = {in_a & ~in_b, ~in_bin};

    assign w_s2_adv = ~r_s2_valid | out_ready;
    assign w_s1_adv = ~r_s1_valid | w_s2_adv;
    assign in_ready = w_s1_adv;

    ling_hc_sub_tree u_tree (
        .i_f_p      (w_p[10:0]),
        .i_f_g      (w_g[11:0]),
        .o_f_h_1_0  (w_h_1_0),
        .o_f_h_3_0  (w_h_3_0),
        .o_f_span   (w_span),
        .i_b_p      (r_p[11:0]),
        .i_b_g_even (w_g_even),
        .i_b_h_1_0  (r_h_1_0),
        .i_b_h_3_0  (r_h_3_0),
        .i_b_span   (r_span),
        .o_b_h      (w_h),
        .o_b_c      (w_c)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_geven
            assign w_g_even[gi] = r_g[2*gi];
        end
        for (gi = 0; gi < LING_W; gi++) begin : g_sum
            assign w_diff[gi] = (r_p[gi+1] ^ w_h[gi+1]) | (r_g[gi+1] & w_c[gi+1]);
        end
    endgenerate

    assign w_cout = r_p[LING_W] & w_h[LING_W];
    assign w_ovf  = (r_a_msb ^ r_b_msb) & (w_diff[LING_W-1] ^ r_a_msb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_p        <= '0;
            r_g        <= '0;
            r_h_1_0    <= 1'b0;
            r_h_3_0    <= 1'b0;
            r_span     <= '0;
            r_a_msb    <= 1'b0;
            r_b_msb    <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_p     <= w_p;
                r_g     <= w_g;
                r_h_1_0 <= w_h_1_0;
                r_h_3_0 <= w_h_3_0;
                r_span  <= w_span;
                r_a_msb <= in_a[LING_W-1];
                r_b_msb <= in_b[LING_W-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_diff     <= '0;
            r_bout     <= 1'b0;
            r_zero     <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_diff <= w_diff;
                r_bout <= ~w_cout;
                r_zero <= (w_diff == '0);
                r_ovf  <= w_ovf;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_diff  = r_diff;
    assign out_bout  = r_bout;
    assign out_zero  = r_zero;
    assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_ling_hc_subtractor_pipe.sv
// Scoreboard bench for ling_hc_subtractor_pipe: the driver pushes expected
// results on acceptance, an independent monitor pops and compares on output.
module tb_ling_hc_subtractor_pipe;

    typedef struct packed {
        logic [11:0] diff;
        logic        bout;
        logic        zero;
        logic        ovf;
    } exp_t;

    typedef struct packed {
        logic [11:0] a;
        logic [11:0] b;
        logic        bin;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_a = '0;
    logic [11:0] in_b = '0;
    logic        in_bin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_diff;
    logic        out_bout;
    logic        out_zero;
    logic        out_ovf;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   n_out = 0;
    bit   rand_ready = 1'b0;

    always #5 clk = ~clk;

    ling_hc_subtractor_pipe #(.WIDTH(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_diff  (out_diff),
        .out_bout  (out_bout),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf)
    );

    function automatic exp_t model(logic [11:0] a, logic [11:0] b, logic bin);
        logic [12:0] d;
        exp_t r;
        d      = {1'b0, a} - {1'b0, b} - {12'b0, bin};
        r.diff = d[11:0];
        r.bout = d[12];
        r.zero = (d[11:0] == 12'h000);
        r.ovf  = (a[11] != b[11]) && (d[11] != a[11]);
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(logic [11:0] a, logic [11:0] b, logic bin, exp_t e);
        int t = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_bin   = bin;
        #1;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got in_ready=0 want 1 (a=%h b=%h)", a, b);
        end else begin
            sb_q.push_back(e);
            $display("IN  a=%h b=%h bin=%0d exp diff=%h bout=%0d zero=%0d ovf=%0d",
                     a, b, bin, e.diff, e.bout, e.zero, e.ovf);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb_q.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_empty", sb_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: compares every delivered beat and checks hold stability under stall.
    initial begin
        exp_t act;
        exp_t prev;
        exp_t e;
        bit   prev_stall;
        prev_stall = 1'b0;
        prev       = '0;
        forever begin
            @(negedge clk);
            #1;
            act = {out_diff, out_bout, out_zero, out_ovf};
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (!out_valid || act !== prev) begin
                        failures++;
                        $display("FAIL hold_stable: got v=%0d %h want v=1 %h", out_valid, act, prev);
                    end
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_out: got %h want no beat", act);
                    end else begin
                        e = sb_q.pop_front();
                        n_out++;
                        $display("OUT diff=%h bout=%0d zero=%0d ovf=%0d", out_diff, out_bout, out_zero, out_ovf);
                        if (act !== e) begin
                            failures++;
                            $display("FAIL result: got %h want %h", act, e);
                        end
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev       = act;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t dir_tab[10];
        vec_t bp_tab[4];
        int   base;
        time  t0;
        logic [11:0] ra;
        logic [11:0] rb;
        logic        rbin;

        //                a        b        bin    diff     bout  zero  ovf
        dir_tab[0] = {12'h005, 12'h003, 1'b0, 12'h002, 1'b0, 1'b0, 1'b0};
        dir_tab[1] = {12'h000, 12'h001, 1'b0, 12'hFFF, 1'b1, 1'b0, 1'b0};
        dir_tab[2] = {12'h7FF, 12'h7FF, 1'b1, 12'hFFF, 1'b1, 1'b0, 1'b0};
        dir_tab[3] = {12'h800, 12'h001, 1'b0, 12'h7FF, 1'b0, 1'b0, 1'b1};
        dir_tab[4] = {12'h123, 12'h123, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0};
        dir_tab[5] = {12'h000, 12'h000, 1'b1, 12'hFFF, 1'b1, 1'b0, 1'b0};
        dir_tab[6] = {12'hFFF, 12'h000, 1'b0, 12'hFFF, 1'b0, 1'b0, 1'b0};
        dir_tab[7] = {12'h7FF, 12'h800, 1'b0, 12'hFFF, 1'b1, 1'b0, 1'b1};
        dir_tab[8] = {12'h000, 12'hFFF, 1'b1, 12'h000, 1'b1, 1'b1, 1'b0};
        dir_tab[9] = {12'hFFF, 12'hFFF, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0};

        bp_tab[0]  = {12'h010, 12'h001, 1'b0, 12'h00F, 1'b0, 1'b0, 1'b0};
        bp_tab[1]  = {12'h100, 12'h0FF, 1'b1, 12'h000, 1'b0, 1'b1, 1'b0};
        bp_tab[2]  = {12'h001, 12'h002, 1'b1, 12'hFFE, 1'b1, 1'b0, 1'b0};
        bp_tab[3]  = {12'hA00, 12'h200, 1'b0, 12'h800, 1'b0, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_fields", 32'({out_diff, out_bout, out_zero, out_ovf}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid_rel", 32'(out_valid), 0);
        @(negedge clk);

        // Directed vectors
        out_ready = 1'b1;
        foreach (dir_tab[k]) send(dir_tab[k].a, dir_tab[k].b, dir_tab[k].bin, dir_tab[k].e);
        drain();

        // Full throughput: 20 back-to-back beats take 20 cycles
        t0 = $time;
        for (int k = 0; k < 20; k++) begin
            ra = 12'($urandom); rb = 12'($urandom); rbin = 1'($urandom);
            send(ra, rb, rbin, model(ra, rb, rbin));
        end
        chk("throughput_time", 32'($time - t0), 200);
        drain();

        // Backpressure
        base      = n_out;
        out_ready = 1'b0;
        fork
            begin
                foreach (bp_tab[k]) send(bp_tab[k].a, bp_tab[k].b, bp_tab[k].bin, bp_tab[k].e);
            end
        join_none
        repeat (6) @(negedge clk);
        #1;
        chk("bp_in_ready", 32'(in_ready), 0);
        chk("bp_accepted", sb_q.size(), 2);
        chk("bp_out_valid", 32'(out_valid), 1);
        @(negedge clk);
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
        wait fork;
        drain();
        chk("bp_delivered", n_out - base, 4);

        // Random stream with random gaps and backpressure
        rand_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            ra = 12'($urandom); rb = 12'($urandom); rbin = 1'($urandom);
            send(ra, rb, rbin, model(ra, rb, rbin));
        end
        rand_ready = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        drain();

        // Reset mid-stream with two beats in flight
        out_ready = 1'b0;
        send(12'h055, 12'h011, 1'b0, model(12'h055, 12'h011, 1'b0));
        send(12'h066, 12'h022, 1'b0, model(12'h066, 12'h022, 1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 1);
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("post_rst_no_stale", 32'(out_valid), 0);
            chk("post_rst_in_ready", 32'(in_ready), 1);
            @(negedge clk);
        end
        base = n_out;
        send(12'h400, 12'h100, 1'b1, {12'h2FF, 1'b0, 1'b0, 1'b0});
        drain();
        chk("post_rst_delivered", n_out - base, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
